ld_st_rg_serial_tx: RTL and testbench
=====================================

// Module: ld_st_rg_serial_tx
// PURPOSE
//  Parallel-in/serial-out transmitter; the unload side of the load/store register bank.
//  Accepts an n-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clk.
//  Sits between a ld_st register bank and a serial link or a downstream serial-in receiver.
//  Supports back-to-back words with no idle cycle between frames.
// PARAMETERS
//  n     4   data word width; legal range 2..32
//  CW    derived = $clog2(n+1); bit-counter width; not overridable
// PORTS
//  clk       in   1  single clock, rising edge
//  clr       in   1  reset, asynchronous, active-high
//  ld_valid  in   1  ld_data holds a word to transmit
//  ld_data   in   n  word to transmit
//  ld_ready  out  1  transmitter accepts a word this cycle
//  sd_out    out  1  serial data bit
//  sd_valid  out  1  sd_out is a live data/parity bit
//  sd_last   out  1  sd_out is the final bit of the frame
//  busy      out  1  frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (clr=1, async): state=IDLE; shift reg, counter, sd_out, sd_valid, sd_last, busy = 0.
//    ld_ready = 0 while clr=1. Reset mid-frame aborts the frame; no further bits are driven.
//  - FSM states: IDLE, SHIFT.
//  - ld_ready = ~clr & (state==IDLE | sd_last). Combinational; no dependence on ld_valid.
//  - Accept: ld_valid & ld_ready at a rising edge -> shreg<=ld_data, cnt<=0, state<=SHIFT.
//  - Latency: first bit (ld_data[0]) appears on sd_out with sd_valid=1 in the cycle after accept.
//  - SHIFT: sd_out=shreg[0], sd_valid=1. Each edge: shreg>>=1 (zero fill), cnt<=cnt+1.
//  - sd_last=1 when cnt==n-1 (no parity), or on the parity bit (parity).
//  - After the last bit with no accept -> IDLE, sd_valid=0, sd_out=0.
//  - Back-to-back: accept on the sd_last cycle reloads shreg and cnt<=0; stays in SHIFT.
//    No gap cycle between frames.
//  - ld_valid while ld_ready=0: ignored. The upstream block holds ld_data until ready.
//  - busy = (state==SHIFT).
//  - The counter never wraps: max value n (parity) or n-1, so CW bits suffice.
// CONFIGURATION
//  - LD_ST_PARITY_EN defined: frame = n data bits + 1 even-parity bit (^ld_data, captured at accept).
//    The frame is n+1 cycles; sd_last is on the parity bit.
//  - LD_ST_PARITY_EN undefined: frame = n data bits; no parity logic or storage is built.
// STRUCTURE
//  - Package ld_st_pkg: state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1; function clog2.
//  - Sub-module ld_st_bit_cnt (CW-bit up-counter, sync load-zero, async clr, terminal-count output).
//  - Top holds the FSM, shift register and parity bit.
// TESTING
//  1) clr pulse mid-idle -> all outputs 0; ld_ready=1 the cycle after clr drops.
//  2) n=4, ld_data=4'b1011 accepted -> next 4 cycles sd_out=1,1,0,1.
//     sd_valid=1 for those 4 cycles; sd_last only on cycle 4; then IDLE.
//  3) Back-to-back 4'hA then 4'h5, ld_valid held -> 8 contiguous bits 0,1,0,1,1,0,1,0.
//     Second accept happens on the first sd_last cycle; sd_valid never drops.
//  4) ld_valid asserted during bit 2 of a frame -> not accepted (ld_ready=0).
//     Accepted on the sd_last cycle; ld_data is unchanged until then.
//  5) clr asserted during bit 2 of 4'hF -> sd_valid/sd_out/busy 0 immediately (async).
//     After release, a new word 4'h3 transmits cleanly as 1,1,0,0.
//  6) LD_ST_PARITY_EN, 4'b0111 -> 5 bits 1,1,1,0,1 (parity 1); sd_last on bit 5.
//     4'b0011 -> parity bit 0.

Source files
------------

// File: rtl/ld_st_pkg.sv
// Shared definitions for the ld_st serial transmitter: FSM encodings, frame sizing, clog2 helper.
// Parity framing is selected by LD_ST_PARITY_EN.
package ld_st_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef LD_ST_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ld_st_bit_cnt.sv
// Bit-position counter for the serial transmitter: synchronous clear-to-zero, increment enable,
// asynchronous clr, and a terminal-count flag at LAST.
module ld_st_bit_cnt #(
    parameter int CW   = 3,
    parameter int LAST = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tc = (cnt_reg == CW'(LAST));

endmodule

// File: rtl/ld_st_rg_serial_tx.sv
// Parallel-in/serial-out transmitter, LSB first, back-to-back frames without gaps.
// Define LD_ST_PARITY_EN to append an even-parity bit to every frame.
module ld_st_rg_serial_tx
    import ld_st_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld_valid,
    input  logic [n-1:0] ld_data,
    output logic         ld_ready,
    output logic         sd_out,
    output logic         sd_valid,
    output logic         sd_last,
    output logic         busy
);

    localparam int CW   = clog2(n + 1);
    localparam int W    = n + PAR_BITS;
    localparam int LAST = n - 1 + PAR_BITS;

    state_t         state_reg;
    state_t         state_next;
    logic [W-1:0]   shreg_reg;
    logic [W-1:0]   load_word;
    logic           tc;
    logic           accept;
    logic           cnt_clear;

`ifdef LD_ST_PARITY_EN
    // Parity rides in the top of the shift register so it falls out after the data bits.
    assign load_word = {^ld_data, ld_data};
`else
    assign load_word = ld_data;
`endif

    assign busy     = (state_reg == ST_SHIFT);
    assign sd_valid = busy;
    assign sd_out   = busy & shreg_reg[0];
    assign sd_last  = busy & tc;
    assign ld_ready = ~clr & (~busy | sd_last);
    assign accept   = ld_valid & ld_ready;

    // Clearing on the final bit keeps the counter from ever stepping past LAST.
    assign cnt_clear = accept | (busy & tc);

    ld_st_bit_cnt #(
        .CW   (CW),
        .LAST (LAST)
    ) u_bit_cnt (
        .clk  (clk),
        .clr  (clr),
        .load (cnt_clear),
        .en   (busy),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (tc && !accept) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shreg_reg <= '0;
        end else if (accept) begin
            shreg_reg <= load_word;
        end else if (busy) begin
            shreg_reg <= shreg_reg >> 1;
        end
    end

endmodule

// File: tb/tb_ld_st_rg_serial_tx.sv
// Scoreboard bench for ld_st_rg_serial_tx (n=4): accepted words push their expected bit
// sequence; a negedge monitor pops and compares every live serial bit.
module tb_ld_st_rg_serial_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic       ld_valid;
    logic [3:0] ld_data;
    logic       ld_ready;
    logic       sd_out;
    logic       sd_valid;
    logic       sd_last;
    logic       busy;

`ifdef LD_ST_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    typedef struct {
        logic d;
        logic last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_acc;

    ld_st_rg_serial_tx #(.n(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .sd_out   (sd_out),
        .sd_valid (sd_valid),
        .sd_last  (sd_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // seq[i] is the i-th transmitted bit; bit 4 is the hand-computed parity bit.
    task automatic expect_frame(input logic [4:0] seq);
        for (int i = 0; i < FLEN; i++) begin
            exp_t e;
            e.d    = seq[i];
            e.last = (i == FLEN - 1);
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [3:0] w, input logic [4:0] seq);
        int n_wait;
        n_wait   = 0;
        ld_valid = 1'b1;
        ld_data  = w;
        @(negedge clk);
        while (ld_ready !== 1'b1 && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        if (ld_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=ld_ready %b required=1 word %h", ld_ready, w);
            ld_valid = 1'b0;
        end else begin
            expect_frame(seq);
            @(posedge clk);
            acc_cyc = cyc;
            #1;
            $display("accept word=%h cycle=%0d", w, acc_cyc);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy !== 1'b0 || q.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("idle_busy", busy, 0);
        chk("idle_sd_valid", sd_valid, 0);
        chk("queue_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (clr === 1'b0 && sd_valid === 1'b1) begin
            exp_t e;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit actual=sd_out %b required=no live bit", sd_out);
            end else begin
                e = q.pop_front();
                chk("sd_bit_last", {sd_out, sd_last}, {e.d, e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr      = 1'b1;
        ld_valid = 1'b0;
        ld_data  = 4'h0;
        #1;
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_sd_valid", sd_valid, 0);
        chk("rst_sd_out", sd_out, 0);
        chk("rst_sd_last", sd_last, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ld_ready, 1);

        // clr pulse while idle
        @(posedge clk); #1 clr = 1'b1;
        #1;
        chk("idle_clr_ready", ld_ready, 0);
        chk("idle_clr_busy", busy, 0);
        chk("idle_clr_valid", sd_valid, 0);
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        chk("idle_clr_release_ready", ld_ready, 1);

        // single frame 1011 -> 1,1,0,1 (parity 1)
        @(posedge clk); #1;
        send(4'b1011, 5'b11011);
        ld_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", sd_valid, 1);
        chk("latency_bit0", sd_out, 1);
        repeat (FLEN) @(negedge clk);
        chk("after_frame_busy", busy, 0);
        chk("after_frame_sd_out", sd_out, 0);
        wait_idle();

        // back-to-back A then 5 -> 0,1,0,1,1,0,1,0
        @(posedge clk); #1;
        send(4'hA, 5'b01010);
        first_acc = acc_cyc;
        send(4'h5, 5'b00101);
        ld_valid = 1'b0;
        chk("b2b_gap", acc_cyc - first_acc, FLEN);
        wait_idle();

        // request during bit 2 is held off until the last bit
        @(posedge clk); #1;
        send(4'hC, 5'b01100);
        first_acc = acc_cyc;
        ld_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        ld_valid = 1'b1;
        ld_data  = 4'h6;
        #1;
        chk("midframe_ready", ld_ready, 0);
        send(4'h6, 5'b00110);
        ld_valid = 1'b0;
        chk("midframe_accept_at_last", acc_cyc - first_acc, FLEN);
        wait_idle();

        // clr during bit 2 of F aborts the frame
        @(posedge clk); #1;
        send(4'hF, 5'b01111);
        ld_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        chk("abort_sd_valid", sd_valid, 0);
        chk("abort_sd_out", sd_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ld_ready, 0);
        q.delete();
        @(posedge clk); #1 clr = 1'b0;
        send(4'h3, 5'b00011);
        ld_valid = 1'b0;
        wait_idle();

`ifdef LD_ST_PARITY_EN
        // 0111 -> 1,1,1,0 then parity 1
        @(posedge clk); #1;
        send(4'b0111, 5'b10111);
        ld_valid = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        send(4'b0011, 5'b00011);
        ld_valid = 1'b0;
        wait_idle();
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
